sprite_layer_sequencer: RTL and testbench

Per-pixel sprite compositor that time-shares one sprite index ROM and one combinational 16-entry sprite palette between NUM_SLOTS on-screen sprites (tanks, shells). For each pixel request it scans slots in fixed priority order (slot 0 on top) and returns the colour of the first opaque sprite texel, or BG_RGB if no slot covers the pixel. Palette index 0 is the transparent key. The block sits between the VGA draw-coordinate source and the colour mapper.

---
 rtl/sprite_pkg.sv | 12 +
 rtl/sprite_slot_hit.sv | 38 +++
 rtl/sprite_layer_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sprite_layer_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite layer sequencer.
package sprite_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} seq_state_t;

    typedef logic [11:0] rgb12_t;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
    localparam int DEF_SPR_W = 32;
    localparam int DEF_SPR_H = 32;

endpackage

// File: rtl/sprite_slot_hit.sv
// Combinational hit test and ROM address generation for a single sprite slot.
module sprite_slot_hit
    import sprite_pkg::*;
#(
    parameter int SPR_W  = DEF_SPR_W,
    parameter int SPR_H  = DEF_SPR_H,
    parameter int ADDR_W = 14
) (
    input  logic              i_en,
    input  logic [9:0]        i_slot_x,
    input  logic [9:0]        i_slot_y,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [9:0]        i_req_x,
    input  logic [9:0]        i_req_y,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_addr
);

    // 11-bit window bounds so a sprite near x/y=1023 never wraps to the left/top edge
    logic [10:0] w_px, w_py, w_x0, w_y0, w_x1, w_y1, w_dx, w_dy;
    logic [ADDR_W-1:0] w_off;

    assign w_px = {1'b0, i_req_x};
    assign w_py = {1'b0, i_req_y};
    assign w_x0 = {1'b0, i_slot_x};
    assign w_y0 = {1'b0, i_slot_y};
    assign w_x1 = w_x0 + 11'(SPR_W);
    assign w_y1 = w_y0 + 11'(SPR_H);
    assign w_dx = w_px - w_x0;
    assign w_dy = w_py - w_y0;

    assign o_hit = i_en && (w_px >= w_x0) && (w_px < w_x1)
                        && (w_py >= w_y0) && (w_py < w_y1);

    assign w_off  = ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_dx);
    assign o_addr = i_base + w_off;

endmodule

// File: rtl/sprite_layer_sequencer.sv
// Per-pixel sprite compositor: scans slots in priority order sharing one ROM and palette.
module sprite_layer_sequencer
    import sprite_pkg::*;
#(
    parameter int     NUM_SLOTS = 4,
    parameter int     SPR_W     = DEF_SPR_W,
    parameter int     SPR_H     = DEF_SPR_H,
    parameter int     ADDR_W    = 14,
    parameter rgb12_t BG_RGB    = 12'h000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_we,
    input  logic [2:0]        i_cfg_slot,
    input  logic              i_cfg_en,
    input  logic [9:0]        i_cfg_x,
    input  logic [9:0]        i_cfg_y,
    input  logic [ADDR_W-1:0] i_cfg_base,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [9:0]        i_req_x,
    input  logic [9:0]        i_req_y,
    output logic              o_rom_rd,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [3:0]        i_rom_data,
    output logic [3:0]        o_pal_index,
    input  rgb12_t            i_pal_rgb,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output rgb12_t            o_out_rgb,
    output logic              o_out_hit
);

    seq_state_t r_state, w_state_next;
    logic [2:0] r_s, w_s_next;
    logic [9:0] r_req_x, r_req_y, w_req_x_next, w_req_y_next;
    rgb12_t     r_out_rgb, w_out_rgb_next;
    logic       r_out_hit, w_out_hit_next;

    // Slot table padded to 8 entries; slots beyond NUM_SLOTS stay disabled
    logic              w_slot_en   [0:7];
    logic [9:0]        w_slot_x    [0:7];
    logic [9:0]        w_slot_y    [0:7];
    logic [ADDR_W-1:0] w_slot_base [0:7];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            localparam bit LIVE = (gi < NUM_SLOTS);
            logic              r_en;
            logic [9:0]        r_x, r_y;
            logic [ADDR_W-1:0] r_base;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_en   <= 1'b0;
                    r_x    <= '0;
                    r_y    <= '0;
                    r_base <= '0;
                end else if (LIVE && i_cfg_we && (i_cfg_slot == 3'(gi))) begin
                    r_en   <= i_cfg_en;
                    r_x    <= i_cfg_x;
                    r_y    <= i_cfg_y;
                    r_base <= i_cfg_base;
                end
            end

            assign w_slot_en[gi]   = r_en;
            assign w_slot_x[gi]    = r_x;
            assign w_slot_y[gi]    = r_y;
            assign w_slot_base[gi] = r_base;
        end
    endgenerate

    logic              w_hit;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    sprite_slot_hit #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (ADDR_W)
    ) u_hit (
        .i_en     (w_slot_en[r_s]),
        .i_slot_x (w_slot_x[r_s]),
        .i_slot_y (w_slot_y[r_s]),
        .i_base   (w_slot_base[r_s]),
        .i_req_x  (r_req_x),
        .i_req_y  (r_req_y),
        .o_hit    (w_hit),
        .o_addr   (w_addr)
    );

    assign w_last = (r_s == 3'(NUM_SLOTS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_s       <= '0;
            r_req_x   <= '0;
            r_req_y   <= '0;
            r_out_rgb <= '0;
            r_out_hit <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_s       <= w_s_next;
            r_req_x   <= w_req_x_next;
            r_req_y   <= w_req_y_next;
            r_out_rgb <= w_out_rgb_next;
            r_out_hit <= w_out_hit_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_s_next       = r_s;
        w_req_x_next   = r_req_x;
        w_req_y_next   = r_req_y;
        w_out_rgb_next = r_out_rgb;
        w_out_hit_next = r_out_hit;
        o_rom_rd       = 1'b0;
        o_rom_addr     = '0;
        o_pal_index    = TRANSPARENT_IDX;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_req_x_next = i_req_x;
                    w_req_y_next = i_req_y;
                    w_s_next     = '0;
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (w_hit) begin
                    o_rom_rd     = 1'b1;
                    o_rom_addr   = w_addr;
                    w_state_next = WAIT;
                end else if (w_last) begin
                    w_out_rgb_next = BG_RGB;
                    w_out_hit_next = 1'b0;
                    w_state_next   = DONE;
                end else begin
                    w_s_next = r_s + 3'd1;
                end
            end
            WAIT: begin
                o_pal_index = i_rom_data;
                if (i_rom_data != TRANSPARENT_IDX) begin
                    w_out_rgb_next = i_pal_rgb;
                    w_out_hit_next = 1'b1;
                    w_state_next   = DONE;
                end else if (w_last) begin
                    w_out_rgb_next = BG_RGB;
                    w_out_hit_next = 1'b0;
                    w_state_next   = DONE;
                end else begin
                    w_s_next     = r_s + 3'd1;
                    w_state_next = SCAN;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_out_rgb   = r_out_rgb;
    assign o_out_hit   = r_out_hit;

endmodule

// File: tb/tb_sprite_layer_sequencer.sv
// Scoreboard bench for sprite_layer_sequencer with a behavioural ROM and palette.
module tb_sprite_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_slot = '0;
    logic        cfg_en = 1'b0;
    logic [9:0]  cfg_x = '0, cfg_y = '0;
    logic [13:0] cfg_base = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_x = '0, req_y = '0;
    logic        rom_rd;
    logic [13:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic [3:0]  pal_index;
    logic [11:0] pal_rgb;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_rgb;
    logic        out_hit;

    logic [3:0]  rom_mem [0:16383];
    logic [11:0] pal_mem [0:15];

    typedef struct {
        logic [11:0] rgb;
        logic        hit;
        int          lat;
        int          nrd;
        int          addr;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = -100;

    sprite_layer_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_we    (cfg_we),
        .i_cfg_slot  (cfg_slot),
        .i_cfg_en    (cfg_en),
        .i_cfg_x     (cfg_x),
        .i_cfg_y     (cfg_y),
        .i_cfg_base  (cfg_base),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_x     (req_x),
        .i_req_y     (req_y),
        .o_rom_rd    (rom_rd),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_pal_index (pal_index),
        .i_pal_rgb   (pal_rgb),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_rgb   (out_rgb),
        .o_out_hit   (out_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_rd) rom_data <= rom_mem[rom_addr];
    assign pal_rgb = pal_mem[pal_index];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (req_valid && req_ready && !rst) accept_cyc = cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts ROM reads per pixel and scores each result once as out_valid rises
    int   mon_seen_acc = -100;
    int   mon_nrd = 0;
    int   mon_addr = -1;
    logic mon_seen_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_seen_valid = 1'b0;
        end else begin
            if (accept_cyc != mon_seen_acc) begin
                mon_nrd = 0;
                mon_addr = -1;
                mon_seen_acc = accept_cyc;
            end
            if (rom_rd) begin
                if (mon_nrd == 0) mon_addr = int'(rom_addr);
                mon_nrd++;
            end
            if (out_valid && !mon_seen_valid) begin
                mon_seen_valid = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("pixel result rgb=%03h hit=%0d lat=%0d rom_reads=%0d", out_rgb, out_hit,
                             cyc - accept_cyc + 1, mon_nrd);
                    check("out_rgb", 32'(out_rgb), 32'(e.rgb));
                    check("out_hit", 32'(out_hit), 32'(e.hit));
                    check("latency", cyc - accept_cyc + 1, e.lat);
                    check("rom_rd_count", mon_nrd, e.nrd);
                    if (e.addr >= 0) check("rom_addr", mon_addr, e.addr);
                end
            end
            if (!out_valid) mon_seen_valid = 1'b0;
        end
    end

    task automatic cfg(input int slot, input int en, input int x, input int y, input int base);
        @(negedge clk);
        cfg_we = 1'b1; cfg_slot = 3'(slot); cfg_en = 1'(en);
        cfg_x = 10'(x); cfg_y = 10'(y); cfg_base = 14'(base);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int exp_waits);
        int waits = 0;
        req_x = 10'(x); req_y = 10'(y); req_valid = 1'b1;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("accept_wait", waits, exp_waits);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || out_valid) && n < 100);
        check("result_timeout", 32'(n >= 100), 32'd0);
    endtask

    task automatic txn(input int x, input int y, input logic [11:0] rgb, input logic hit,
                       input int lat, input int nrd, input int addr);
        exp_t e;
        e.rgb = rgb; e.hit = hit; e.lat = lat; e.nrd = nrd; e.addr = addr;
        sb.push_back(e);
        send(x, y, 0);
        wait_done();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16384; i++) rom_mem[i] = 4'h0;
        for (int i = 0; i < 16; i++) pal_mem[i] = 12'hFFF;
        pal_mem[3] = 12'h0F0; pal_mem[5] = 12'h0AB; pal_mem[7] = 12'hF07; pal_mem[9] = 12'h123;
        rom_mem[170] = 4'd3;
        rom_mem[1024 + 101] = 4'd0;
        rom_mem[2048 + 101] = 4'd7;
        rom_mem[4096 + 340] = 4'd9;
        rom_mem[8192 + 1023] = 4'd5;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_rgb", 32'(out_rgb), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_rom_rd", 32'(rom_rd), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_pal_index", 32'(pal_index), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_rst", 32'(req_ready), 32'd1);

        // Slot 0 opaque texel: best-case latency
        cfg(0, 1, 100, 50, 0);
        txn(110, 55, 12'h0F0, 1'b1, 3, 1, 170);

        // Backpressure: result held, no new request accepted until one cycle after release
        begin
            exp_t e;
            e.rgb = 12'h0F0; e.hit = 1'b1; e.lat = 3; e.nrd = 1; e.addr = 170;
            sb.push_back(e);
        end
        out_ready = 1'b0;
        send(110, 55, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_timeout", 32'(n >= 20), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_rgb", 32'(out_rgb), 32'h0F0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        begin
            exp_t e;
            e.rgb = 12'h000; e.hit = 1'b0; e.lat = 5; e.nrd = 0; e.addr = -1;
            sb.push_back(e);
        end
        send(0, 0, 1);
        wait_done();

        // Disabled slot no longer hits
        cfg(0, 0, 100, 50, 0);
        txn(110, 55, 12'h000, 1'b0, 5, 0, -1);

        // Overlap: slot 0 transparent falls through to slot 1
        cfg(0, 1, 200, 200, 1024);
        cfg(1, 1, 200, 200, 2048);
        txn(205, 203, 12'hF07, 1'b1, 5, 2, 1125);

        // Right-edge slot, no wrap
        cfg(0, 0, 0, 0, 0);
        cfg(1, 0, 0, 0, 0);
        cfg(2, 1, 1000, 0, 4096);
        txn(1020, 10, 12'h123, 1'b1, 5, 1, 4436);
        txn(5, 10, 12'h000, 1'b0, 5, 0, -1);

        // Window edges on slot 3
        cfg(2, 0, 0, 0, 0);
        cfg(3, 1, 300, 400, 8192);
        txn(331, 431, 12'h0AB, 1'b1, 6, 1, 9215);
        txn(332, 431, 12'h000, 1'b0, 5, 0, -1);
        txn(300, 432, 12'h000, 1'b0, 5, 0, -1);

        // All slots hit but transparent: worst-case latency
        for (int s = 0; s < 4; s++) cfg(s, 1, 600, 600, 12288);
        txn(600, 600, 12'h000, 1'b0, 9, 4, 12288);

        // Reset during WAIT drops the pixel and clears slot enables
        cfg(0, 1, 100, 50, 0);
        send(110, 55, 0);
        n = 0;
        while (pal_index == 4'd0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait", 32'(pal_index), 32'd3);
        rst = 1'b1;
        #1;
        check("arst_pal_index", 32'(pal_index), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_rgb", 32'(out_rgb), 32'd0);
        check("arst_out_hit", 32'(out_hit), 32'd0);
        check("arst_rom_rd", 32'(rom_rd), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        txn(110, 55, 12'h000, 1'b0, 5, 0, -1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
